// File: rtl/alu_serial_seq_pkg.sv
// rtl/alu_serial_seq_pkg.sv - shared constants and types for the bit-serial ALU
//
// Purpose: opcode values seen on ctrl_op, the 1-bit slice Operation codes,
// FSM state encoding and small decode helpers used by alu_serial_seq.
package alu_serial_seq_pkg;

  // Opcodes presented on ctrl_op
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  // Operation codes understood by alu_1_bit_f
  localparam logic [1:0] SLICE_AND = 2'b00;
  localparam logic [1:0] SLICE_OR  = 2'b01;
  localparam logic [1:0] SLICE_ADD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ADD and SUB share the adder path and are the only ops with overflow
  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic [1:0] slice_op(input logic [1:0] op);
    case (op)
      OP_AND:  return SLICE_AND;
      OP_OR:   return SLICE_OR;
      default: return SLICE_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// rtl/alu_serial_seq_if.sv - start/busy/done handshake and operand/result bus
//
// Purpose: groups the request and result signals of the serial ALU.
//   master: drives start, ctrl_op, data_operandA/B; observes results.
//   slave : the ALU; drives busy, done, data_result and the flags.
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       ctrl_op;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_result;
  logic             overflow;
  logic             isNotEqual;
  logic             isLessThan;

  modport master (
    output start, ctrl_op, data_operandA, data_operandB,
    input  busy, done, data_result, overflow, isNotEqual, isLessThan
  );

  modport slave (
    input  start, ctrl_op, data_operandA, data_operandB,
    output busy, done, data_result, overflow, isNotEqual, isLessThan
  );

endinterface

// File: rtl/alu_1_bit_f.sv
// rtl/alu_1_bit_f.sv - one-bit ALU slice (AND / OR / full-adder)
//
// Purpose: combinational 1-bit ALU.
//   operandA, operandB : data bits
//   Ainvert, Binvert   : invert the respective operand before use
//   carry_in           : adder carry input
//   Operation          : 00 AND, 01 OR, 10 ADD, 11 reserved (out=0)
//   out                : selected result bit
//   carry_out          : adder carry output
//   overflow           : carry_in XOR carry_out; meaningful only on the MSB slice
module alu_1_bit_f (
  input  logic       operandA,
  input  logic       operandB,
  input  logic       Ainvert,
  input  logic       Binvert,
  input  logic       carry_in,
  input  logic [1:0] Operation,
  output logic       out,
  output logic       carry_out,
  output logic       overflow
);

  logic a;
  logic b;
  logic sum;

  assign a         = operandA ^ Ainvert;
  assign b         = operandB ^ Binvert;
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);
  assign overflow  = carry_in ^ carry_out;

  always_comb begin
    out = 1'b0;
    case (Operation)
      2'b00:   out = a & b;
      2'b01:   out = a | b;
      2'b10:   out = sum;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU controller around one alu_1_bit_f
//
// Purpose: streams two WIDTH-bit operands LSB-first through a single 1-bit
// slice, one bit per clock, and assembles the result and flags.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_serial_seq_if.slave
//           start/ctrl_op/data_operandA/data_operandB in,
//           busy/done/data_result/overflow/isNotEqual/isLessThan out
// Timing: start accepted in IDLE; WIDTH RUN cycles; one DONE cycle with done=1.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  alu_serial_seq_if.slave   bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nx;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry_ff;
  logic             ovf_q;
  logic             ne_q;
  logic             lt_q;

  logic             busy_c;
  logic             done_c;
  logic             accept;
  logic             run;
  logic             last_bit;

  logic             s_binv;
  logic             s_cin;
  logic [1:0]       s_op;
  logic             s_out;
  logic             s_cout;
  logic             s_ovf;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    accept = 1'b0;
    run    = 1'b0;
    case (state)
      ST_IDLE: accept = bus.start;
      ST_RUN: begin
        busy_c = 1'b1;
        run    = 1'b1;
      end
      ST_DONE: begin
        busy_c = 1'b1;
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign last_bit = run && (cnt == LAST);

  // ---------------- slice control ----------------
  // SUB is A + ~B + 1: invert B and inject the +1 as the bit-0 carry.
  assign s_binv = (op_q == OP_SUB);
  assign s_op   = slice_op(op_q);
  assign s_cin  = (cnt == '0) ? (op_q == OP_SUB) : carry_ff;

  alu_1_bit_f u_slice (
    .operandA  (a_sh[0]),
    .operandB  (b_sh[0]),
    .Ainvert   (1'b0),
    .Binvert   (s_binv),
    .carry_in  (s_cin),
    .Operation (s_op),
    .out       (s_out),
    .carry_out (s_cout),
    .overflow  (s_ovf)
  );

  // New bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_nx = {s_out, res_q[WIDTH-1:1]};

  // ---------------- datapath ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      op_q     <= OP_AND;
      cnt      <= '0;
      carry_ff <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else if (accept) begin
      a_sh     <= bus.data_operandA;
      b_sh     <= bus.data_operandB;
      op_q     <= bus.ctrl_op;
      cnt      <= '0;
      carry_ff <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else if (run) begin
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      carry_ff <= s_cout;
      res_q    <= res_nx;
      cnt      <= cnt + 1'b1;
      // Flags are taken from the final result so they are valid with done.
      if (last_bit) begin
        ovf_q <= is_arith(op_q) & s_ovf;
        ne_q  <= (op_q == OP_SUB) & (|res_nx);
        lt_q  <= (op_q == OP_SUB) & (res_nx[WIDTH-1] ^ s_ovf);
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.data_result = res_q;
  assign bus.overflow    = ovf_q;
  assign bus.isNotEqual  = ne_q;
  assign bus.isLessThan  = lt_q;

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Multi-cycle, bit-serial ALU controller. Streams two WIDTH-bit operands LSB-first through one instance of the team's 1-bit ALU slice, alu_1_bit_f, one bit per clock.
- Owns the slice's control inputs (Ainvert, Binvert, Operation, carry_in) and a carry flip-flop. Collects out, carry_out and overflow into a result register.
- Serves as the small-area execute unit for non-critical datapaths. Same start/busy/done handshake as other multi-cycle units.

Parameters:
- WIDTH, 32, operand/result width in bits, at least 2.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- ctrl_op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB (A-B).
- data_operandA  input  WIDTH  operand A; captured on accepted start.
- data_operandB  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse when the result becomes valid.
- data_result  output  WIDTH  result; held until the next accepted start.
- overflow  output  1  signed overflow; ADD/SUB only, else 0.
- isNotEqual  output  1  SUB only: result != 0.
- isLessThan  output  1  SUB only: signed A < B, i.e. result[WIDTH-1] XOR overflow.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE.
  - busy, done, data_result, overflow, isNotEqual, isLessThan all 0.
  - Carry flip-flop and bit counter cleared.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1. Latches A, B and ctrl_op into shift registers. Counter=0. Clears data_result and all flags.
  - RUN: one bit per cycle, bit i on RUN cycle i, i=0..WIDTH-1.
    - Slice inputs: operandA=A_sh[0], operandB=B_sh[0], Ainvert=0.
    - Binvert=1 for SUB only.
    - Operation: 00 for AND, 01 for OR, 10 for ADD/SUB.
    - carry_in: on bit 0, 1 for SUB, else 0; on bits 1..WIDTH-1, the carry flip-flop.
    - Each edge: carry_ff<=carry_out. The slice's out is shifted into result bit WIDTH-1 while the result register shifts right; A_sh and B_sh shift right.
    - After bit WIDTH-1 the result sits LSB-aligned.
    - On the bit WIDTH-1 edge: overflow<=slice overflow if op is ADD/SUB, else 0.
    - When counter==WIDTH-1 -> DONE.
  - DONE: exactly one cycle.
    - done=1.
    - isNotEqual = OR-reduction of data_result (SUB only).
    - isLessThan = data_result[WIDTH-1] XOR overflow (SUB only).
    - Flags are registered, valid with done, and held afterward.
    - DONE -> IDLE.
- Latency: start accepted on edge N. done high in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles start-to-done. Next start accepted in the cycle after done.
- start while busy=1: ignored; no queuing. Operand inputs may change freely after acceptance.
- Reset mid-RUN: operation aborted, no done pulse, outputs zeroed on that edge.
- Final carry_out is not reported; unsigned carry is out of scope.
- data_result is not meaningful while busy=1. It is valid from the done cycle until the next accepted start.

Decomposition:
- Shared package/header: opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11. State encodings ST_IDLE, ST_RUN, ST_DONE. Slice Operation codes SLICE_AND/SLICE_OR/SLICE_ADD.
- One sub-module: the existing alu_1_bit_f, instantiated once unmodified.
- Counter, shift registers and FSM stay in this module.

Test Plan:
- ADD 0x00000005 + 0x00000003 -> done exactly 33 cycles after start; data_result=0x00000008, overflow=0, isNotEqual=0, isLessThan=0.
- SUB 0x7FFFFFFF - 0xFFFFFFFF -> data_result=0x80000000, overflow=1, isNotEqual=1, isLessThan=0. SUB 0x00000003-0x00000007 -> 0xFFFFFFFC, isLessThan=1.
- SUB 0x12345678 - 0x12345678 -> data_result=0, isNotEqual=0, isLessThan=0. AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000. OR of the same operands -> 0xFFF0FFF0; overflow=0 for both.
- Second start pulsed while busy, with different operands -> ignored. The first result is delivered unchanged; only one done pulse.
- reset asserted at RUN cycle 10 -> next cycle busy=0, data_result=0. No done pulse; a fresh start then completes normally.
- Back-to-back: start held high continuously -> operations complete every WIDTH+2 cycles. Each done pulse is one cycle wide, with the correct result per latched operand pair.
